// File: rtl/vout_mode_pkg.sv
// vout_mode_pkg: output mode and state types, plus the per-mode sync timing table
package vout_mode_pkg;
    typedef enum logic [1:0] {
        MODE_800  = 2'd0,
        MODE_1024 = 2'd1,
        MODE_1280 = 2'd2,
        MODE_RSVD = 2'd3
    } mode_t;
    typedef enum logic [1:0] {HOLD, MUTE, RUN, WAIT_VB} state_t;
    typedef struct packed {
        logic [15:0] h_total;
        logic [15:0] h_sync;
        logic [15:0] h_bporch;
        logic [15:0] h_res;
        logic [15:0] v_total;
        logic [15:0] v_sync;
        logic [15:0] v_bporch;
        logic [15:0] v_res;
        logic        hs_pol;
        logic        vs_pol;
    } timing_t;
    // The reserved code never reaches here; it falls back to 800x600 for safety
    function automatic timing_t mode_params(input mode_t mode);
        return mode == MODE_1024 ? timing_t'{16'd1344, 16'd136, 16'd160, 16'd1024, 16'd806, 16'd6, 16'd29, 16'd768, 1'b0, 1'b0} :
               mode == MODE_1280 ? timing_t'{16'd1650, 16'd40, 16'd220, 16'd1280, 16'd750, 16'd5, 16'd20, 16'd720, 1'b1, 1'b1} :
                                   timing_t'{16'd1056, 16'd128, 16'd88, 16'd800, 16'd628, 16'd4, 16'd23, 16'd600, 1'b1, 1'b1};
    endfunction
endpackage

// File: rtl/vout_mode_ctrl.sv
// vout_mode_ctrl: holds the display mode, switching it only at a frame boundary
// while keeping the sync generator in reset and the RGB output muted until it settles
module vout_mode_ctrl
    import vout_mode_pkg::*;
#(
    parameter int HOLD_CYC    = 16,
    parameter int MUTE_FRAMES = 2,
    parameter int RD_HRES     = 640,
    parameter int RD_VRES     = 480
) (
    input  logic        pix_clk,
    input  logic        hdmi_rst_n,
    input  logic        I_mode_req,
    input  logic [1:0]  I_mode_sel,
    input  logic        I_vs,
    output logic [15:0] O_h_total,
    output logic [15:0] O_h_sync,
    output logic [15:0] O_h_bporch,
    output logic [15:0] O_h_res,
    output logic [15:0] O_v_total,
    output logic [15:0] O_v_sync,
    output logic [15:0] O_v_bporch,
    output logic [15:0] O_v_res,
    output logic [15:0] O_rd_hres,
    output logic [15:0] O_rd_vres,
    output logic        O_hs_pol,
    output logic        O_vs_pol,
    output logic        O_gen_rst_n,
    output logic        O_mute,
    output logic        O_busy,
    output logic [1:0]  O_mode_cur,
    output logic        O_err
);
    state_t     state;
    timing_t    tim;
    mode_t      mode_cur, pend_mode, nxt_mode;
    logic       pend, nxt_pend, vs_d, vs_act, frame_edge, req_ok;
    logic       gen_rst_n, mute, busy, err;
    logic [7:0] hold_cnt;
    logic [3:0] frm_cnt;

    assign vs_act     = I_vs ~^ tim.vs_pol;
    assign frame_edge = vs_act & ~vs_d;
    assign req_ok     = I_mode_req & (I_mode_sel != 2'd3);
    // A request in this very cycle wins over whatever is already pending
    assign nxt_pend   = req_ok | pend;
    assign nxt_mode   = req_ok ? mode_t'(I_mode_sel) : pend_mode;

    always_ff @(posedge pix_clk or negedge hdmi_rst_n) begin
        if (!hdmi_rst_n) begin
            state     <= HOLD;
            tim       <= mode_params(MODE_800);
            mode_cur  <= MODE_800;
            pend_mode <= MODE_800;
            pend      <= 1'b0;
            vs_d      <= 1'b0;
            hold_cnt  <= '0;
            frm_cnt   <= '0;
            gen_rst_n <= 1'b0;
            mute      <= 1'b1;
            busy      <= 1'b1;
            err       <= 1'b0;
        end else begin
            err       <= I_mode_req & (I_mode_sel == 2'd3);
            vs_d      <= vs_act;
            pend      <= nxt_pend;
            pend_mode <= nxt_mode;
            case (state)
                HOLD: begin
                    if (hold_cnt == 8'(HOLD_CYC - 1)) begin
                        state     <= MUTE;
                        hold_cnt  <= '0;
                        gen_rst_n <= 1'b1;
                        vs_d      <= 1'b0;
                    end else begin
                        hold_cnt <= hold_cnt + 8'd1;
                    end
                end
                MUTE: begin
                    if (frame_edge) begin
                        frm_cnt <= frm_cnt + 4'd1;
                        if (frm_cnt + 4'd1 == 4'(MUTE_FRAMES)) begin
                            frm_cnt <= '0;
                            mute    <= 1'b0;
                            if (nxt_pend && nxt_mode != mode_cur) begin
                                state <= WAIT_VB;
                            end else begin
                                state <= RUN;
                                busy  <= 1'b0;
                                pend  <= 1'b0;
                            end
                        end
                    end
                end
                RUN: begin
                    if (nxt_pend && nxt_mode != mode_cur) begin
                        state <= WAIT_VB;
                        busy  <= 1'b1;
                    end else if (nxt_pend) begin
                        pend <= 1'b0;
                    end
                end
                WAIT_VB: begin
                    // New timing lands together with the generator reset
                    if (frame_edge) begin
                        state     <= HOLD;
                        tim       <= mode_params(nxt_mode);
                        mode_cur  <= nxt_mode;
                        pend      <= 1'b0;
                        gen_rst_n <= 1'b0;
                        mute      <= 1'b1;
                    end
                end
                default: state <= HOLD;
            endcase
        end
    end

    assign O_h_total   = tim.h_total;
    assign O_h_sync    = tim.h_sync;
    assign O_h_bporch  = tim.h_bporch;
    assign O_h_res     = tim.h_res;
    assign O_v_total   = tim.v_total;
    assign O_v_sync    = tim.v_sync;
    assign O_v_bporch  = tim.v_bporch;
    assign O_v_res     = tim.v_res;
    assign O_hs_pol    = tim.hs_pol;
    assign O_vs_pol    = tim.vs_pol;
    assign O_rd_hres   = 16'(RD_HRES);
    assign O_rd_vres   = 16'(RD_VRES);
    assign O_gen_rst_n = gen_rst_n;
    assign O_mute      = mute;
    assign O_busy      = busy;
    assign O_mode_cur  = mode_cur;
    assign O_err       = err;
endmodule

// File: tb/tb_vout_mode_ctrl.sv
// tb_vout_mode_ctrl: scoreboarded bench for frame-synchronous mode switching
module tb_vout_mode_ctrl;
    logic        pix_clk = 1'b0, hdmi_rst_n = 1'b0, I_mode_req = 1'b0, I_vs = 1'b0;
    logic [1:0]  I_mode_sel = 2'd0;
    logic [15:0] O_h_total, O_h_sync, O_h_bporch, O_h_res;
    logic [15:0] O_v_total, O_v_sync, O_v_bporch, O_v_res;
    logic [15:0] O_rd_hres, O_rd_vres;
    logic        O_hs_pol, O_vs_pol, O_gen_rst_n, O_mute, O_busy, O_err;
    logic [1:0]  O_mode_cur;

    int  n_tests = 0, n_fail = 0, loads = 0;
    int  exp_q[$];
    bit  pol = 1'b1;
    logic        prev_gen = 1'b0;
    logic [48:0] prev_par;

    int ht[3]  = '{1056, 1344, 1650};
    int hs[3]  = '{128, 136, 40};
    int hb[3]  = '{88, 160, 220};
    int hr[3]  = '{800, 1024, 1280};
    int vt[3]  = '{628, 806, 750};
    int vsy[3] = '{4, 6, 5};
    int vb[3]  = '{23, 29, 20};
    int vr[3]  = '{600, 768, 720};
    bit pp[3]  = '{1'b1, 1'b0, 1'b1};

    vout_mode_ctrl dut (
        .pix_clk(pix_clk), .hdmi_rst_n(hdmi_rst_n), .I_mode_req(I_mode_req), .I_mode_sel(I_mode_sel),
        .I_vs(I_vs), .O_h_total(O_h_total), .O_h_sync(O_h_sync), .O_h_bporch(O_h_bporch),
        .O_h_res(O_h_res), .O_v_total(O_v_total), .O_v_sync(O_v_sync), .O_v_bporch(O_v_bporch),
        .O_v_res(O_v_res), .O_rd_hres(O_rd_hres), .O_rd_vres(O_rd_vres), .O_hs_pol(O_hs_pol),
        .O_vs_pol(O_vs_pol), .O_gen_rst_n(O_gen_rst_n), .O_mute(O_mute), .O_busy(O_busy),
        .O_mode_cur(O_mode_cur), .O_err(O_err)
    );

    initial forever #5 pix_clk = ~pix_clk;

    initial begin
        #500000;
        $display("FAIL watchdog: run did not complete");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Each generator-reset fall outside hdmi reset is a mode load: pop and compare
    always @(negedge pix_clk) begin
        if (hdmi_rst_n && prev_gen && !O_gen_rst_n) begin
            if (exp_q.size() == 0) begin
                check("unexp_load", exp_q.size(), 1);
            end else begin
                int m;
                m = exp_q.pop_front();
                check("ld_mode", O_mode_cur, m);
                check("ld_h_total", O_h_total, ht[m]);
                check("ld_h_sync", O_h_sync, hs[m]);
                check("ld_h_bporch", O_h_bporch, hb[m]);
                check("ld_h_res", O_h_res, hr[m]);
                check("ld_v_total", O_v_total, vt[m]);
                check("ld_v_sync", O_v_sync, vsy[m]);
                check("ld_v_bporch", O_v_bporch, vb[m]);
                check("ld_v_res", O_v_res, vr[m]);
                check("ld_hs_pol", O_hs_pol, pp[m]);
                check("ld_vs_pol", O_vs_pol, pp[m]);
                check("ld_mute", O_mute, 1);
                loads++;
            end
        end
        if ({O_h_total, O_v_total, O_h_res, O_vs_pol} != prev_par)
            check("param_live", O_gen_rst_n, 0);
        prev_par = {O_h_total, O_v_total, O_h_res, O_vs_pol};
        prev_gen = O_gen_rst_n;
    end

    task automatic req(input int sel, input bit push);
        @(negedge pix_clk);
        I_mode_req = 1'b1;
        I_mode_sel = 2'(sel);
        if (push) exp_q.push_back(sel);
        @(negedge pix_clk);
        I_mode_req = 1'b0;
    endtask

    task automatic frame();
        I_vs = pol;
        repeat (3) @(negedge pix_clk);
        I_vs = ~pol;
        repeat (6) @(negedge pix_clk);
    endtask

    task automatic edge_load(input int m, input bit with_req);
        int n = 0;
        int l0;
        l0 = loads;
        if (with_req) begin
            I_mode_req = 1'b1;
            I_mode_sel = 2'(m);
            exp_q.push_back(m);
        end
        I_vs = pol;
        do begin
            @(negedge pix_clk);
            #1;
            I_mode_req = 1'b0;
            n++;
        end while (loads == l0 && n < 10);
        check("load_lat", n <= 2, 1);
        pol  = pp[m];
        I_vs = ~pol;
    endtask

    task automatic hold_wait();
        int c = 0;
        while (!O_gen_rst_n && c < 100) begin
            c++;
            @(negedge pix_clk);
        end
        check("hold_len", c, 16);
    endtask

    task automatic mute_frames();
        frame();
        check("mute_mid", O_mute, 1);
        frame();
        check("mute_end", O_mute, 0);
    endtask

    initial begin
        repeat (3) @(negedge pix_clk);
        check("rst_gen", O_gen_rst_n, 0);
        check("rst_mute", O_mute, 1);
        check("rst_busy", O_busy, 1);
        check("rst_err", O_err, 0);
        check("rst_mode", O_mode_cur, 0);
        check("rst_h_total", O_h_total, 1056);
        check("rst_v_res", O_v_res, 600);
        check("rst_rd_hres", O_rd_hres, 640);
        check("rst_rd_vres", O_rd_vres, 480);
        check("rst_hs_pol", O_hs_pol, 1);
        hdmi_rst_n = 1'b1;
        hold_wait();
        check("hold_h_total", O_h_total, 1056);
        mute_frames();
        check("run_busy", O_busy, 0);
        // mid-frame switch to 1280x720
        repeat (4) @(negedge pix_clk);
        req(2, 1'b1);
        check("wait_busy", O_busy, 1);
        repeat (5) @(negedge pix_clk);
        check("wait_h_total", O_h_total, 1056);
        check("wait_live", O_gen_rst_n, 1);
        check("wait_mute", O_mute, 0);
        edge_load(2, 1'b0);
        check("load_h_total", O_h_total, 1650);
        hold_wait();
        mute_frames();
        // last request wins, including one coinciding with the VS edge
        req(1, 1'b0);
        check("wait2_busy", O_busy, 1);
        repeat (3) @(negedge pix_clk);
        edge_load(2, 1'b1);
        hold_wait();
        mute_frames();
        // negative-polarity mode: mute only clears on falling VS
        req(1, 1'b1);
        edge_load(1, 1'b0);
        hold_wait();
        mute_frames();
        check("m1_busy", O_busy, 0);
        req(3, 1'b0);
        check("err_pulse", O_err, 1);
        @(negedge pix_clk);
        check("err_clear", O_err, 0);
        check("err_busy", O_busy, 0);
        check("err_mode", O_mode_cur, 1);
        req(1, 1'b0);
        check("same_mode_busy", O_busy, 0);
        // request pending across MUTE goes straight to WAIT_VB
        req(2, 1'b1);
        edge_load(2, 1'b0);
        hold_wait();
        req(0, 1'b1);
        mute_frames();
        check("mute_to_wait_busy", O_busy, 1);
        check("mute_to_wait_mode", O_mode_cur, 2);
        edge_load(0, 1'b0);
        hold_wait();
        mute_frames();
        // reset mid-HOLD discards the pending request
        req(1, 1'b1);
        edge_load(1, 1'b0);
        repeat (3) @(negedge pix_clk);
        req(2, 1'b0);
        repeat (3) @(negedge pix_clk);
        hdmi_rst_n = 1'b0;
        #1;
        check("arst_mode", O_mode_cur, 0);
        check("arst_h_total", O_h_total, 1056);
        check("arst_v_res", O_v_res, 600);
        check("arst_vs_pol", O_vs_pol, 1);
        check("arst_gen", O_gen_rst_n, 0);
        check("arst_mute", O_mute, 1);
        check("arst_busy", O_busy, 1);
        pol  = 1'b1;
        I_vs = 1'b0;
        repeat (2) @(negedge pix_clk);
        hdmi_rst_n = 1'b1;
        hold_wait();
        mute_frames();
        check("pend_drop_busy", O_busy, 0);
        check("pend_drop_mode", O_mode_cur, 0);
        repeat (10) @(negedge pix_clk);
        check("pend_drop_idle", O_busy, 0);
        check("sb_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
